// File: rtl/axi_rdata_router.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : axi_rdata_router
// Function : AXI R-channel return router. Round-robin arbitration per master,
//            burst lock until RLast, registered master-side slices.
//            Optional AXI_RDATA_SKID_EN: 2-entry skid slice per master.
// Revision : 1.0 - initial release
// ============================================================================
module axi_rdata_router #(
    parameter int NUM_S     = 3,
    parameter int NUM_M     = 2,
    parameter int ID_BITS   = 4,
    parameter int IDS_BITS  = 8,
    parameter int DATA_BITS = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_S*IDS_BITS-1:0]  S_RID,
    input  logic [NUM_S*DATA_BITS-1:0] S_RData,
    input  logic [NUM_S*2-1:0]         S_RResp,
    input  logic [NUM_S-1:0]           S_RLast,
    input  logic [NUM_S-1:0]           S_RValid,
    output logic [NUM_S-1:0]           S_RReady,
    output logic [NUM_M*ID_BITS-1:0]   M_RID,
    output logic [NUM_M*DATA_BITS-1:0] M_RData,
    output logic [NUM_M*2-1:0]         M_RResp,
    output logic [NUM_M-1:0]           M_RLast,
    output logic [NUM_M-1:0]           M_RValid,
    input  logic [NUM_M-1:0]           M_RReady
);

    localparam int c_SEL_BITS = IDS_BITS - ID_BITS;
    localparam int c_SW       = (NUM_S > 1) ? $clog2(NUM_S) : 1;
    localparam logic [c_SEL_BITS-1:0] c_M_MASK = c_SEL_BITS'((64'd1 << NUM_M) - 64'd1);

    typedef struct packed {
        logic [ID_BITS-1:0]   id;
        logic [DATA_BITS-1:0] data;
        logic [1:0]           resp;
        logic                 last;
    } beat_t;

    logic [c_SEL_BITS-1:0] w_sel [NUM_S];
    logic [NUM_S-1:0]      w_good;
    logic [NUM_S-1:0]      w_bad;
    logic [NUM_S-1:0]      w_req [NUM_M];
    logic [NUM_M-1:0]      w_gnt_vld;
    logic [NUM_M-1:0]      w_accept;
    logic [NUM_M-1:0]      w_fire;
    logic [c_SW-1:0]       w_gnt_idx [NUM_M];
    beat_t                 w_in [NUM_M];

    logic [c_SW-1:0]       r_rr_ptr [NUM_M];
    logic [c_SW-1:0]       r_lock_slv [NUM_M];
    logic [NUM_M-1:0]      r_lock_vld;
    beat_t                 r_head [NUM_M];
    logic [NUM_M-1:0]      r_head_vld;

    function automatic logic [c_SW-1:0] wrap_idx(input logic [c_SW-1:0] base, input int offs);
        int sum;
        sum = int'(base) + offs;
        if (sum >= NUM_S) sum = sum - NUM_S;
        return c_SW'(sum);
    endfunction

    // Select field must be exactly one-hot and inside the populated master range.
    always_comb begin
        for (int s = 0; s < NUM_S; s++) begin
            w_sel[s]  = S_RID[s*IDS_BITS+ID_BITS +: c_SEL_BITS];
            w_good[s] = (w_sel[s] != '0)
                     && ((w_sel[s] & (w_sel[s] - c_SEL_BITS'(1))) == '0)
                     && ((w_sel[s] & ~c_M_MASK) == '0);
            w_bad[s]  = S_RValid[s] && !w_good[s];
        end
        for (int m = 0; m < NUM_M; m++) begin
            for (int s = 0; s < NUM_S; s++) begin
                w_req[m][s] = S_RValid[s] && w_good[s] && w_sel[s][m];
            end
        end
    end

    // Descending scan so the lowest offset from the pointer wins.
    always_comb begin
        for (int m = 0; m < NUM_M; m++) begin
            w_gnt_vld[m] = 1'b0;
            w_gnt_idx[m] = '0;
            if (r_lock_vld[m]) begin
                w_gnt_vld[m] = w_req[m][r_lock_slv[m]];
                w_gnt_idx[m] = r_lock_slv[m];
            end else begin
                for (int i = NUM_S - 1; i >= 0; i--) begin
                    if (w_req[m][wrap_idx(r_rr_ptr[m], i)]) begin
                        w_gnt_vld[m] = 1'b1;
                        w_gnt_idx[m] = wrap_idx(r_rr_ptr[m], i);
                    end
                end
            end
            w_fire[m]    = w_gnt_vld[m] && w_accept[m];
            w_in[m].id   = S_RID[int'(w_gnt_idx[m])*IDS_BITS +: ID_BITS];
            w_in[m].data = S_RData[int'(w_gnt_idx[m])*DATA_BITS +: DATA_BITS];
            w_in[m].resp = S_RResp[int'(w_gnt_idx[m])*2 +: 2];
            w_in[m].last = S_RLast[w_gnt_idx[m]];
        end
    end

    always_comb begin
        for (int s = 0; s < NUM_S; s++) begin
            S_RReady[s] = w_bad[s];
            for (int m = 0; m < NUM_M; m++) begin
                if (w_fire[m] && (w_gnt_idx[m] == c_SW'(s))) S_RReady[s] = 1'b1;
            end
            if (rst) S_RReady[s] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int m = 0; m < NUM_M; m++) begin
                r_lock_vld[m] <= 1'b0;
                r_lock_slv[m] <= '0;
                r_rr_ptr[m]   <= '0;
            end
        end else begin
            for (int m = 0; m < NUM_M; m++) begin
                if (w_fire[m]) begin
                    if (w_in[m].last) begin
                        r_lock_vld[m] <= 1'b0;
                        r_rr_ptr[m]   <= wrap_idx(w_gnt_idx[m], 1);
                    end else begin
                        r_lock_vld[m] <= 1'b1;
                        r_lock_slv[m] <= w_gnt_idx[m];
                    end
                end
            end
        end
    end

`ifdef AXI_RDATA_SKID_EN
    beat_t            r_tail [NUM_M];
    logic [NUM_M-1:0] r_tail_vld;

    // Accept only from registered occupancy: no M_RReady -> S_RReady path.
    always_comb begin
        for (int m = 0; m < NUM_M; m++) begin
            w_accept[m] = !r_tail_vld[m];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_head_vld <= '0;
            r_tail_vld <= '0;
            for (int m = 0; m < NUM_M; m++) begin
                r_head[m] <= '0;
                r_tail[m] <= '0;
            end
        end else begin
            for (int m = 0; m < NUM_M; m++) begin
                if (r_head_vld[m] && M_RReady[m]) begin
                    if (r_tail_vld[m]) begin
                        r_head[m]     <= r_tail[m];
                        r_tail_vld[m] <= 1'b0;
                    end else if (w_fire[m]) begin
                        r_head[m]     <= w_in[m];
                    end else begin
                        r_head_vld[m] <= 1'b0;
                    end
                end else if (w_fire[m]) begin
                    if (!r_head_vld[m]) begin
                        r_head[m]     <= w_in[m];
                        r_head_vld[m] <= 1'b1;
                    end else begin
                        r_tail[m]     <= w_in[m];
                        r_tail_vld[m] <= 1'b1;
                    end
                end
            end
        end
    end
`else
    always_comb begin
        for (int m = 0; m < NUM_M; m++) begin
            w_accept[m] = !r_head_vld[m] || M_RReady[m];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_head_vld <= '0;
            for (int m = 0; m < NUM_M; m++) begin
                r_head[m] <= '0;
            end
        end else begin
            for (int m = 0; m < NUM_M; m++) begin
                if (w_fire[m]) begin
                    r_head[m]     <= w_in[m];
                    r_head_vld[m] <= 1'b1;
                end else if (M_RReady[m]) begin
                    r_head_vld[m] <= 1'b0;
                end
            end
        end
    end
`endif

    always_comb begin
        for (int m = 0; m < NUM_M; m++) begin
            M_RID[m*ID_BITS +: ID_BITS]     = r_head[m].id;
            M_RData[m*DATA_BITS +: DATA_BITS] = r_head[m].data;
            M_RResp[m*2 +: 2]               = r_head[m].resp;
            M_RLast[m]                      = r_head[m].last;
        end
        M_RValid = r_head_vld;
    end

endmodule
`default_nettype wire

// File: tb/tb_axi_rdata_router.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_axi_rdata_router
// Function : Self-checking bench for axi_rdata_router against a queue model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_axi_rdata_router;

    localparam int NUM_S     = 3;
    localparam int NUM_M     = 2;
    localparam int ID_BITS   = 4;
    localparam int IDS_BITS  = 8;
    localparam int DATA_BITS = 32;

    typedef struct packed {
        logic [ID_BITS-1:0]   id;
        logic [DATA_BITS-1:0] data;
        logic [1:0]           resp;
        logic                 last;
    } beat_t;

    logic                       clk = 1'b0;
    logic                       rst;
    logic [NUM_S*IDS_BITS-1:0]  S_RID;
    logic [NUM_S*DATA_BITS-1:0] S_RData;
    logic [NUM_S*2-1:0]         S_RResp;
    logic [NUM_S-1:0]           S_RLast;
    logic [NUM_S-1:0]           S_RValid;
    logic [NUM_S-1:0]           S_RReady;
    logic [NUM_M*ID_BITS-1:0]   M_RID;
    logic [NUM_M*DATA_BITS-1:0] M_RData;
    logic [NUM_M*2-1:0]         M_RResp;
    logic [NUM_M-1:0]           M_RLast;
    logic [NUM_M-1:0]           M_RValid;
    logic [NUM_M-1:0]           M_RReady;

    axi_rdata_router #(
        .NUM_S(NUM_S), .NUM_M(NUM_M), .ID_BITS(ID_BITS),
        .IDS_BITS(IDS_BITS), .DATA_BITS(DATA_BITS)
    ) u_dut (
        .clk(clk), .rst(rst),
        .S_RID(S_RID), .S_RData(S_RData), .S_RResp(S_RResp), .S_RLast(S_RLast),
        .S_RValid(S_RValid), .S_RReady(S_RReady),
        .M_RID(M_RID), .M_RData(M_RData), .M_RResp(M_RResp), .M_RLast(M_RLast),
        .M_RValid(M_RValid), .M_RReady(M_RReady)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Slave-side drivers: one presented beat plus a remaining-burst counter.
    logic [NUM_S-1:0]     drv_vld;
    logic [IDS_BITS-1:0]  drv_id   [NUM_S];
    logic [DATA_BITS-1:0] drv_data [NUM_S];
    logic [1:0]           drv_resp [NUM_S];
    logic                 drv_last [NUM_S];
    int                   bst_rem  [NUM_S];
    logic [IDS_BITS-1:0]  bst_id   [NUM_S];
    int                   hs_cnt   [NUM_S];
    logic [NUM_M-1:0]     mrdy;
    logic                 rst_drv;
    logic [NUM_S-1:0]     seen_srdy;

    // Reference model: per-master queue of delivered-but-unconsumed beats.
    beat_t mq      [NUM_M][$];
    bit    lock_v  [NUM_M];
    int    lock_s  [NUM_M];
    int    ptr     [NUM_M];
    int    log_src [NUM_M][$];

    logic [3:0] bad_sel [5] = '{4'h0, 4'h3, 4'h4, 4'h8, 4'hC};
    int         exp_lock [5] = '{2, 2, 2, 2, 1};

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Returns the addressed master, or -1 when the select field is unusable.
    function automatic int target(input logic [IDS_BITS-1:0] id);
        int hot = 0;
        int m   = -1;
        for (int b = ID_BITS; b < IDS_BITS; b++) begin
            if (id[b]) begin
                hot++;
                m = b - ID_BITS;
            end
        end
        if (hot != 1 || m >= NUM_M) return -1;
        return m;
    endfunction

    task automatic step();
        logic [NUM_S-1:0] exp_rdy;
        logic [NUM_S-1:0] hs;
        int               win;
        int               tgt;
        bit               acc;
        @(negedge clk);
        for (int s = 0; s < NUM_S; s++) begin
            if (!drv_vld[s] && bst_rem[s] > 0) begin
                drv_vld[s]  = 1'b1;
                drv_id[s]   = bst_id[s];
                drv_data[s] = {8'(s), 24'($urandom)};
                drv_resp[s] = 2'($urandom);
                drv_last[s] = (bst_rem[s] == 1);
                bst_rem[s]--;
            end
        end
        rst      = rst_drv;
        M_RReady = mrdy;
        S_RValid = drv_vld;
        for (int s = 0; s < NUM_S; s++) begin
            S_RID[s*IDS_BITS +: IDS_BITS]     = drv_id[s];
            S_RData[s*DATA_BITS +: DATA_BITS] = drv_data[s];
            S_RResp[s*2 +: 2]                 = drv_resp[s];
            S_RLast[s]                        = drv_last[s];
        end
        #1;
        exp_rdy = '0;
        if (!rst_drv) begin
            for (int s = 0; s < NUM_S; s++) begin
                if (drv_vld[s] && target(drv_id[s]) < 0) exp_rdy[s] = 1'b1;
            end
            for (int m = 0; m < NUM_M; m++) begin
`ifdef AXI_RDATA_SKID_EN
                acc = (mq[m].size() < 2);
`else
                acc = (mq[m].size() == 0) || mrdy[m];
`endif
                win = -1;
                if (lock_v[m]) begin
                    if (drv_vld[lock_s[m]] && target(drv_id[lock_s[m]]) == m) win = lock_s[m];
                end else begin
                    for (int i = 0; i < NUM_S; i++) begin
                        int s = (ptr[m] + i) % NUM_S;
                        if (win < 0 && drv_vld[s] && target(drv_id[s]) == m) win = s;
                    end
                end
                if (win >= 0 && acc) exp_rdy[win] = 1'b1;
            end
        end
        check("s_rready", S_RReady, exp_rdy);
        for (int m = 0; m < NUM_M; m++) begin
            check("m_rvalid", M_RValid[m], mq[m].size() > 0);
            if (mq[m].size() > 0)
                check("m_beat", {M_RID[m*ID_BITS +: ID_BITS], M_RData[m*DATA_BITS +: DATA_BITS],
                                 M_RResp[m*2 +: 2], M_RLast[m]}, mq[m][0]);
            if (M_RValid[m] && mrdy[m]) log_src[m].push_back(int'(M_RData[m*DATA_BITS+24 +: 8]));
        end
        seen_srdy = S_RReady;
        hs        = drv_vld & exp_rdy;
        @(posedge clk);
        if (rst_drv) begin
            for (int m = 0; m < NUM_M; m++) begin
                mq[m].delete();
                lock_v[m] = 1'b0;
                ptr[m]    = 0;
            end
            for (int s = 0; s < NUM_S; s++) begin
                drv_vld[s] = 1'b0;
                bst_rem[s] = 0;
            end
        end else begin
            for (int m = 0; m < NUM_M; m++) begin
                if (mq[m].size() > 0 && mrdy[m]) void'(mq[m].pop_front());
            end
            for (int s = 0; s < NUM_S; s++) begin
                if (hs[s]) begin
                    hs_cnt[s]++;
                    drv_vld[s] = 1'b0;
                    tgt = target(drv_id[s]);
                    if (tgt >= 0) begin
                        mq[tgt].push_back({drv_id[s][ID_BITS-1:0], drv_data[s], drv_resp[s], drv_last[s]});
                        if (drv_last[s]) begin
                            lock_v[tgt] = 1'b0;
                            ptr[tgt]    = (s + 1) % NUM_S;
                        end else begin
                            lock_v[tgt] = 1'b1;
                            lock_s[tgt] = s;
                        end
                    end
                end
            end
        end
    endtask

    task automatic clear_logs();
        for (int m = 0; m < NUM_M; m++) log_src[m].delete();
    endtask

    initial begin
        int base;
        int rm;
        rst      = 1'b1;
        rst_drv  = 1'b0;
        S_RID    = '0;
        S_RData  = '0;
        S_RResp  = '0;
        S_RLast  = '0;
        S_RValid = '0;
        M_RReady = '0;
        mrdy     = '1;
        drv_vld  = '0;
        for (int s = 0; s < NUM_S; s++) begin
            drv_id[s] = '0; drv_data[s] = '0; drv_resp[s] = '0; drv_last[s] = 1'b0;
            bst_rem[s] = 0; bst_id[s] = '0; hs_cnt[s] = 0;
        end
        for (int m = 0; m < NUM_M; m++) begin
            lock_v[m] = 1'b0; lock_s[m] = 0; ptr[m] = 0;
        end
        repeat (2) @(posedge clk);
        #1;
        check("rst_m_rvalid", M_RValid, '0);
        check("rst_m_rid",    M_RID,    '0);
        check("rst_m_rdata",  M_RData,  '0);
        check("rst_m_rresp",  M_RResp,  '0);
        check("rst_m_rlast",  M_RLast,  '0);
        check("rst_s_rready", S_RReady, '0);

        // Single beat to master 0.
        drv_vld[0] = 1'b1; drv_id[0] = 8'h13; drv_data[0] = 32'hDEADBEEF;
        drv_resp[0] = 2'b00; drv_last[0] = 1'b1;
        step();
        #1;
        check("single_vld",  M_RValid, 2'b01);
        check("single_id",   M_RID[3:0], 4'h3);
        check("single_data", M_RData[31:0], 32'hDEADBEEF);
        repeat (2) step();

        // Round-robin between S0 and S1 on master 1.
        clear_logs();
        for (int c = 0; c < 12 && log_src[1].size() < 4; c++) begin
            for (int s = 0; s < 2; s++) begin
                if (!drv_vld[s] && bst_rem[s] == 0) begin
                    bst_rem[s] = 1;
                    bst_id[s]  = (s == 0) ? 8'h25 : 8'h2A;
                end
            end
            step();
        end
        check("rr_count", log_src[1].size() >= 4, 1'b1);
        for (int i = 0; i < 4 && i < log_src[1].size(); i++) check("rr_order", log_src[1][i], i % 2);
        repeat (4) step();

        // Burst lock: S2 4-beat burst, S1 competes from beat 2.
        clear_logs();
        bst_rem[2] = 4; bst_id[2] = 8'h1B;
        step();
        bst_rem[1] = 1; bst_id[1] = 8'h1C;
        for (int c = 0; c < 20 && log_src[0].size() < 5; c++) step();
        check("lock_count", log_src[0].size() >= 5, 1'b1);
        for (int i = 0; i < 5 && i < log_src[0].size(); i++) check("lock_order", log_src[0][i], exp_lock[i]);
        repeat (3) step();

        // Parallel traffic with master 0 stalled.
        clear_logs();
        bst_rem[0] = 2; bst_id[0] = 8'h14;
        bst_rem[2] = 5; bst_id[2] = 8'h27;
        mrdy = 2'b10;
        repeat (4) step();
        check("par_m1_beats", log_src[1].size(), 3);
        check("stall_s0_rdy", seen_srdy[0], 1'b0);
        mrdy = 2'b11;
        repeat (8) step();

        // Unusable select fields are sunk, never forwarded.
        for (int k = 0; k < 5; k++) begin
            drv_vld[1] = 1'b1; drv_id[1] = {bad_sel[k], 4'h3};
            drv_data[1] = 32'h5A5A_0000 + k; drv_resp[1] = 2'b10; drv_last[1] = 1'b1;
            step();
            check("bad_rdy", seen_srdy[1], 1'b1);
            #1;
            check("bad_fwd", M_RValid, 2'b00);
        end
        bst_rem[1] = 1; bst_id[1] = 8'h17;
        repeat (3) step();

        // Reset in the middle of a burst.
        base = hs_cnt[1];
        bst_rem[1] = 4; bst_id[1] = 8'h15;
        for (int c = 0; c < 10 && hs_cnt[1] < base + 2; c++) step();
        check("rst_pre_beats", hs_cnt[1] - base, 2);
        rst_drv = 1'b1;
        step();
        rst_drv = 1'b0;
        #1;
        check("rst_mid_vld", M_RValid, 2'b00);
        bst_rem[0] = 2; bst_id[0] = 8'h16;
        step();
        check("rst_fresh_rdy", seen_srdy[0], 1'b1);
        repeat (3) step();

        // Randomized traffic.
        for (int c = 0; c < 3000; c++) begin
            for (int m = 0; m < NUM_M; m++) mrdy[m] = ($urandom_range(3, 0) != 0);
            for (int s = 0; s < NUM_S; s++) begin
                if (!drv_vld[s] && bst_rem[s] == 0 && $urandom_range(9, 0) < 4) begin
                    if ($urandom_range(9, 0) < 8) begin
                        rm = $urandom_range(NUM_M - 1, 0);
                        bst_id[s]  = {4'(1 << rm), 4'($urandom)};
                        bst_rem[s] = $urandom_range(4, 1);
                    end else begin
                        bst_id[s]  = {bad_sel[$urandom_range(4, 0)], 4'($urandom)};
                        bst_rem[s] = 1;
                    end
                end
            end
            rst_drv = (c % 700 == 699);
            step();
            rst_drv = 1'b0;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
